// File: rtl/fir_out_serializer.sv
// fir_out_serializer: buffers 32-bit FIR results in a DEPTH-word FIFO and streams them LSB-first as bytes.
// Define FIR_SER_FRAME_EN to send header byte 8'hA5 ahead of every word.
module fir_out_serializer #(
  parameter int DEPTH  = 2,
  parameter int NBYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            in_dat,
  input  logic                   in_vld,
  output logic [7:0]             out_dat,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   busy,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

`ifdef FIR_SER_FRAME_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BYTE} state_t;
  localparam state_t S_FIRST = S_HDR;
`else
  typedef enum logic [1:0] {S_IDLE, S_BYTE} state_t;
  localparam state_t S_FIRST = S_BYTE;
`endif

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  state_t        r_state;
  logic [KW-1:0] r_k;
  logic [7:0]    r_out_dat;
  logic          r_out_vld;
  logic          r_busy;
  logic          r_ovf;

  state_t        w_state_nxt;
  logic [KW-1:0] w_k_nxt;
  logic          w_xfer;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic [AW:0]   w_level_nxt;
  logic [AW-1:0] w_rptr_nxt;
  logic [31:0]   w_head_nxt;
  logic [7:0]    w_out_dat_nxt;
  logic          w_out_vld_nxt;
  logic          w_busy_nxt;

  always_comb begin
    w_xfer      = r_out_vld && out_rdy;
    w_pop       = 1'b0;
    w_state_nxt = r_state;
    w_k_nxt     = r_k;

    case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_state_nxt = S_FIRST;
          w_k_nxt     = '0;
        end
      end
`ifdef FIR_SER_FRAME_EN
      S_HDR: begin
        if (w_xfer) w_state_nxt = S_BYTE;
      end
`endif
      S_BYTE: begin
        if (w_xfer) begin
          if (r_k == K_LAST) begin
            w_pop   = 1'b1;
            w_k_nxt = '0;
          end else begin
            w_k_nxt = r_k + KW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_full      = (r_level == FULL);
    w_push      = in_vld && (!w_full || w_pop);
    w_drop      = in_vld && w_full && !w_pop;
    w_level_nxt = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    w_rptr_nxt  = w_pop ? r_rptr + AW'(1) : r_rptr;

    if (w_pop) w_state_nxt = (w_level_nxt != '0) ? S_FIRST : S_IDLE;

    // A word pushed on the pop edge of the last stored word is not in memory yet.
    w_head_nxt = (w_push && (r_wptr == w_rptr_nxt)) ? in_dat : r_mem[w_rptr_nxt];

    w_out_vld_nxt = 1'b0;
    w_out_dat_nxt = '0;
    case (w_state_nxt)
`ifdef FIR_SER_FRAME_EN
      S_HDR: begin
        w_out_vld_nxt = 1'b1;
        w_out_dat_nxt = 8'hA5;
      end
`endif
      S_BYTE: begin
        w_out_vld_nxt = 1'b1;
        w_out_dat_nxt = w_head_nxt[{w_k_nxt, 3'b000} +: 8];
      end
      default: ;
    endcase

    w_busy_nxt = (w_level_nxt != '0) || (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_out_dat <= '0;
      r_out_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      r_rptr    <= w_rptr_nxt;
      r_level   <= w_level_nxt;
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_out_dat <= w_out_dat_nxt;
      r_out_vld <= w_out_vld_nxt;
      r_busy    <= w_busy_nxt;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign out_dat = r_out_dat;
  assign out_vld = r_out_vld;
  assign busy    = r_busy;
  assign ovf     = r_ovf;
  assign level   = r_level;

endmodule

// File: tb/tb_fir_out_serializer.sv
// Bench for fir_out_serializer: vector table plus hand sequences, bytes checked against a scoreboard queue.
module tb_fir_out_serializer;

`ifdef FIR_SER_FRAME_EN
  localparam bit FRAME = 1'b1;
`else
  localparam bit FRAME = 1'b0;
`endif
  localparam int NB = FRAME ? 5 : 4;

  logic        clk;
  logic        rst;
  logic [31:0] in_dat;
  logic        in_vld;
  logic [7:0]  out_dat;
  logic        out_vld;
  logic        out_rdy;
  logic        busy;
  logic        ovf;
  logic [1:0]  level;

  fir_out_serializer #(.DEPTH(2), .NBYTES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_dat  (in_dat),
    .in_vld  (in_vld),
    .out_dat (out_dat),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .busy    (busy),
    .ovf     (ovf),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] q [$];
  bit         mon_en  = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_dat;
  logic [7:0] exp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every accepted byte is matched against the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("hold_vld", out_vld, 1);
        chk("hold_dat", out_dat, prev_dat);
      end
      if (!out_vld) begin
        chk("idle_dat", out_dat, 0);
      end else if (out_rdy && !rst) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h, expected no byte (t=%0t)", out_dat, $time);
        end else begin
          exp_b = q.pop_front();
          chk("byte", out_dat, exp_b);
        end
      end
      prev_stall = out_vld && !out_rdy && !rst;
      prev_dat   = out_dat;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_word(input logic [31:0] w, input bit keep,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    if (keep) begin
      if (FRAME) q.push_back(8'hA5);
      q.push_back(b0);
      q.push_back(b1);
      q.push_back(b2);
      q.push_back(b3);
    end
    in_dat = w;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    in_dat = '0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || out_vld || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q_empty", q.size(), 0);
    chk("drain_vld", out_vld, 0);
    chk("drain_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    in_vld  = 1'b0;
    in_dat  = '0;
    out_rdy = 1'b0;
    q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_dat", out_dat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_level", level, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_vld", out_vld, 0);
  endtask

  typedef struct {
    logic [31:0] word;
    int          stall;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [7:0] first;
    first   = FRAME ? 8'hA5 : v.b0;
    out_rdy = (v.stall == 0);
    push_word(v.word, 1'b1, v.b0, v.b1, v.b2, v.b3);
    @(negedge clk);
    chk("lat_not_early", out_vld, 0);
    chk("lat_level", level, 1);
    @(negedge clk);
    chk("lat_vld", out_vld, 1);
    chk("lat_first_byte", out_dat, first);
    chk("lat_busy", busy, 1);
    if (v.stall == 0) begin
      repeat (NB) @(negedge clk);
      chk("thru_done_vld", out_vld, 0);
      chk("thru_q_empty", q.size(), 0);
      chk("thru_busy", busy, 0);
      @(posedge clk); #1;
    end else begin
      for (int i = 1; i < v.stall; i++) begin
        @(negedge clk);
        chk("stall_byte", out_dat, first);
      end
      @(posedge clk); #1;
      out_rdy = 1'b1;
      drain(50);
    end
    chk("vec_level_end", level, 0);
  endtask

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h1234_5678, 0, 8'h78, 8'h56, 8'h34, 8'h12};
    vecs[1] = '{32'hDEAD_BEEF, 5, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    vecs[2] = '{32'h0000_00FF, 0, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{32'h8001_7F80, 2, 8'h80, 8'h7F, 8'h01, 8'h80};
    vecs[4] = '{32'h0102_0304, 0, 8'h04, 8'h03, 8'h02, 8'h01};

    do_reset();
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Back-to-back words: no gap at the word boundary.
    out_rdy = 1'b1;
    push_word(32'h4433_2211, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
    push_word(32'h8877_6655, 1'b1, 8'h55, 8'h66, 8'h77, 8'h88);
    for (int i = 0; i < 2 * NB; i++) begin
      @(negedge clk);
      chk("b2b_vld", out_vld, 1);
    end
    @(negedge clk);
    chk("b2b_end_vld", out_vld, 0);
    chk("b2b_q_empty", q.size(), 0);
    @(posedge clk); #1;

    // Push lands on the pop edge of the only stored word.
    push_word(32'hF0E0_D0C0, 1'b1, 8'hC0, 8'hD0, 8'hE0, 8'hF0);
    repeat (NB) @(posedge clk);
    #1;
    push_word(32'h0B0A_0908, 1'b1, 8'h08, 8'h09, 8'h0A, 8'h0B);
    @(negedge clk);
    chk("lvl1_pushpop_vld", out_vld, 1);
    chk("lvl1_pushpop_level", level, 1);
    drain(50);

    // Overflow: third word dropped, ovf sticky until reset.
    do_reset();
    push_word(32'hA1A2_A3A4, 1'b1, 8'hA4, 8'hA3, 8'hA2, 8'hA1);
    push_word(32'hB1B2_B3B4, 1'b1, 8'hB4, 8'hB3, 8'hB2, 8'hB1);
    chk("ovf_before", ovf, 0);
    push_word(32'hC1C2_C3C4, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("ovf_level", level, 2);
    chk("ovf_set", ovf, 1);
    @(posedge clk); #1;
    out_rdy = 1'b1;
    drain(60);
    chk("ovf_sticky", ovf, 1);
    do_reset();

    // Full FIFO, push coincides with acceptance of the head word's last byte.
    push_word(32'h1111_2222, 1'b1, 8'h22, 8'h22, 8'h11, 8'h11);
    push_word(32'h3344_5566, 1'b1, 8'h66, 8'h55, 8'h44, 8'h33);
    @(negedge clk);
    chk("full_level", level, 2);
    @(posedge clk); #1;
    out_rdy = 1'b1;
    repeat (NB - 1) @(posedge clk);
    #1;
    chk("full_last_byte", out_dat, 8'h11);
    push_word(32'h7788_99AA, 1'b1, 8'hAA, 8'h99, 8'h88, 8'h77);
    @(negedge clk);
    chk("full_pushpop_level", level, 2);
    chk("full_pushpop_ovf", ovf, 0);
    drain(60);

    // Reset after two data bytes of a word.
    out_rdy = 1'b1;
    push_word(32'h1122_3344, 1'b1, 8'h44, 8'h33, 8'h22, 8'h11);
    repeat (3 + NB - 4) @(posedge clk);
    #1;
    chk("mid_remaining", q.size(), 2);
    rst     = 1'b1;
    out_rdy = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    q.delete();
    @(posedge clk); #1;
    chk("mid_after_rst_vld", out_vld, 0);
    run_vec('{32'h0000_00AA, 0, 8'hAA, 8'h00, 8'h00, 8'h00});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_out_serializer.md
# fir_out_serializer

Output byte serializer placed directly downstream of the FIR core. It captures each 32-bit filter result on a one-cycle strobe and buffers it in a small word FIFO. It then streams the buffered words out as bytes over an 8-bit valid/ready interface. This lets the result leave through the 8 dedicated output pins of the tile without being truncated to 16 bits.

## Interface
Parameters:
- DEPTH, 2: FIFO depth in 32-bit words; power of two, at least 2.
- NBYTES, 4: bytes per word; fixed at 4 for a 32-bit result.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset; synchronous, active-high.
- in_dat, input, 32: FIR result word.
- in_vld, input, 1: one-cycle strobe; pushes in_dat into the FIFO.
- out_dat, output, 8: current output byte.
- out_vld, output, 1: out_dat holds a valid byte.
- out_rdy, input, 1: downstream accepts the byte.
- busy, output, 1: FIFO non-empty or serialization in progress.
- ovf, output, 1: sticky overflow flag.
- level, output, $clog2(DEPTH)+1: number of occupied FIFO words.

## Operation
- FIFO: circular buffer of DEPTH words with wrapping read and write pointers.
  - Push occurs on in_vld.
  - Pop occurs when the last byte of the head word is accepted.
- Full push:
  - in_vld while full and no pop in the same cycle: the word is dropped, ovf is set, and ovf stays 1 until rst.
  - in_vld while full with a pop in the same cycle: the push is accepted and level is unchanged.
- State machine:
  - IDLE -> BYTE when the FIFO is non-empty. With FIR_SER_FRAME_EN defined, the path is IDLE -> HDR -> BYTE.
  - BYTE uses byte index k (0..NBYTES-1) and sends the head word LSB-first: byte k = head[8k+7:8k].
  - A byte is transferred when out_vld && out_rdy. Each transfer increments k.
  - When the transfer at k = NBYTES-1 completes, the head word is popped and k returns to 0.
  - After that pop: if the FIFO is still non-empty, the next state is HDR with framing or BYTE without framing, with no bubble. Otherwise the next state is IDLE.
- Output stability:
  - out_dat is stable while out_vld && !out_rdy.
  - out_vld never drops without a transfer, except on rst.
- Output registers: out_dat, out_vld, busy and level are registered.
- Idle value: out_dat = 8'h00 whenever out_vld = 0.
- Reset mid-operation: the FIFO is flushed and the partially sent word is discarded. No byte is emitted in the cycle after rst deasserts.

## Timing
- Values after rst: out_dat = 0, out_vld = 0, busy = 0, ovf = 0, level = 0, pointers = 0, state = IDLE.
- Latency: with in_vld at edge t into an empty FIFO, out_vld = 1 and the first byte appear after edge t+1.
  - The first byte is byte0, or the header byte when framing is enabled.
- Throughput: with out_rdy held at 1, one byte per cycle with no gaps across word boundaries.
  - Without framing: 4 cycles per word.
  - With framing: 5 cycles per word.
- level and busy update in the same cycle as the push or pop that changes them.

## Configuration
- Macro: FIR_SER_FRAME_EN.
- Defined: each word is preceded by the header byte 8'hA5 in state HDR, which uses the same handshake as data bytes.
- Undefined: state HDR does not exist and words are sent back-to-back with no header.

## Test plan
- Single word, out_rdy held at 1:
  - Stimulus: push 32'h1234_5678.
  - Response: out_dat = 78, 56, 34, 12 on 4 consecutive cycles starting at t+1.
  - Then out_vld = 0 and busy = 0.
- Backpressure:
  - Stimulus: push 32'hDEAD_BEEF, hold out_rdy = 0 for 5 cycles, then assert it.
  - Response: out_dat holds EF with out_vld = 1 throughout the stall, then EF, BE, AD, DE are sent.
- Overflow, DEPTH = 2:
  - Stimulus: out_rdy = 0; push A, B, C.
  - Response: level = 2 and ovf = 1. When out_rdy is released, only A and B appear.
  - ovf remains 1 until rst.
- Push and pop in the same cycle when full:
  - Stimulus: full FIFO; in_vld coincides with acceptance of the last byte of the head word.
  - Response: the new word is kept, level stays at 2, ovf stays 0.
- Reset mid-word:
  - Stimulus: assert rst after 2 bytes of a word have been sent.
  - Response: the next cycle shows out_vld = 0 and level = 0.
  - The next pushed word 32'h0000_00AA starts at byte AA.
- Framing, FIR_SER_FRAME_EN defined:
  - Stimulus: push 32'h0102_0304.
  - Response: bytes A5, 04, 03, 02, 01 are sent.
